// File: rtl/arbiter_rr_4x4_if.sv
// Signal bundle between the round-robin arbiter and the two FIFO banks.
// master is the arbiter side; slave is the FIFO-bank side.
interface arbiter_rr_4x4_if #(
  parameter int unsigned WORD_SIZE = 6
);
  logic [WORD_SIZE-1:0] data_in0;
  logic [WORD_SIZE-1:0] data_in1;
  logic [WORD_SIZE-1:0] data_in2;
  logic [WORD_SIZE-1:0] data_in3;
  logic                 fifo_empty0;
  logic                 fifo_empty1;
  logic                 fifo_empty2;
  logic                 fifo_empty3;
  logic                 almost_full0;
  logic                 almost_full1;
  logic                 almost_full2;
  logic                 almost_full3;
  logic                 pop0;
  logic                 pop1;
  logic                 pop2;
  logic                 pop3;
  logic                 push0;
  logic                 push1;
  logic                 push2;
  logic                 push3;
  logic [WORD_SIZE-1:0] data_out;
  logic                 idle;

  modport master (
    input  data_in0, data_in1, data_in2, data_in3,
    input  fifo_empty0, fifo_empty1, fifo_empty2, fifo_empty3,
    input  almost_full0, almost_full1, almost_full2, almost_full3,
    output pop0, pop1, pop2, pop3,
    output push0, push1, push2, push3,
    output data_out, idle
  );

  modport slave (
    output data_in0, data_in1, data_in2, data_in3,
    output fifo_empty0, fifo_empty1, fifo_empty2, fifo_empty3,
    output almost_full0, almost_full1, almost_full2, almost_full3,
    input  pop0, pop1, pop2, pop3,
    input  push0, push1, push2, push3,
    input  data_out, idle
  );
endinterface

// File: rtl/arbiter_rr_4x4.sv
// Round-robin pop arbiter between four input FIFOs and four output FIFOs;
// each popped word is pushed two cycles later to the FIFO named by its two MSBs.
module arbiter_rr_4x4 #(
  parameter int unsigned WORD_SIZE = 6
) (
  input logic              clk,
  input logic              reset_L,
  arbiter_rr_4x4_if.master bus
);

  logic [WORD_SIZE-1:0] din_w [4];
  logic [3:0]           empty_w;
  logic [3:0]           afull_w;
  logic                 stall_w;

  assign din_w[0] = bus.data_in0;
  assign din_w[1] = bus.data_in1;
  assign din_w[2] = bus.data_in2;
  assign din_w[3] = bus.data_in3;
  assign empty_w  = {bus.fifo_empty3, bus.fifo_empty2, bus.fifo_empty1, bus.fifo_empty0};
  assign afull_w  = {bus.almost_full3, bus.almost_full2, bus.almost_full1, bus.almost_full0};
  assign stall_w  = |afull_w;

  // S0: grant
  logic [3:0] pop_q, pop_d;
  logic [3:0] elig_w;
  logic [1:0] last_q, last_d;
  logic [1:0] cand_w;
  logic       found_w;

  // pop_q masks the input popped last cycle: its empty flag has not caught up yet
  always_comb begin
    elig_w  = stall_w ? '0 : (~empty_w & ~pop_q);
    pop_d   = '0;
    last_d  = last_q;
    found_w = 1'b0;
    cand_w  = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand_w = last_q + 2'(k);
      if (!found_w && elig_w[cand_w]) begin
        found_w        = 1'b1;
        pop_d[cand_w]  = 1'b1;
        last_d         = cand_w;
      end
    end
  end

  // S1: remember which input's read data arrives this cycle
  logic       s1_v_q;
  logic [1:0] s1_src_q;
  logic [1:0] pop_idx_w;

  always_comb begin
    pop_idx_w = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (pop_q[i]) pop_idx_w = 2'(i);
    end
  end

  // S2: route the selected word
  logic [WORD_SIZE-1:0] sel_w;
  logic [1:0]           dst_w;
  logic [3:0]           push_q, push_d;
  logic [WORD_SIZE-1:0] dout_q, dout_d;
  logic                 idle_q, idle_d;

  assign sel_w = din_w[s1_src_q];
  assign dst_w = sel_w[WORD_SIZE-1 -: 2];

  always_comb begin
    push_d = '0;
    dout_d = dout_q;
    if (s1_v_q) begin
      push_d[dst_w] = 1'b1;
      dout_d        = sel_w;
    end
  end

  // idle drops with a new pop and rises the cycle after the final push
  assign idle_d = ~(|pop_d) & ~(|pop_q) & ~s1_v_q & (&empty_w);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pop_q    <= '0;
      last_q   <= 2'd3;
      s1_v_q   <= 1'b0;
      s1_src_q <= '0;
      push_q   <= '0;
      dout_q   <= '0;
      idle_q   <= 1'b1;
    end else begin
      pop_q    <= pop_d;
      last_q   <= last_d;
      s1_v_q   <= |pop_q;
      s1_src_q <= pop_idx_w;
      push_q   <= push_d;
      dout_q   <= dout_d;
      idle_q   <= idle_d;
    end
  end

  assign bus.pop0     = pop_q[0];
  assign bus.pop1     = pop_q[1];
  assign bus.pop2     = pop_q[2];
  assign bus.pop3     = pop_q[3];
  assign bus.push0    = push_q[0];
  assign bus.push1    = push_q[1];
  assign bus.push2    = push_q[2];
  assign bus.push3    = push_q[3];
  assign bus.data_out = dout_q;
  assign bus.idle     = idle_q;

endmodule

// File: doc/arbiter_rr_4x4.md
# arbiter_rr_4x4

Four-input round-robin read arbiter that sits directly downstream of the input FIFOs (each managed by a `control_logic` instance) and upstream of four output FIFOs. It pops words from non-empty input FIFOs in round-robin order and routes each word to the output FIFO selected by its two MSBs. It throttles globally on any output FIFO's `almost_full`. The block contains the only pop/push sequencing between the two FIFO banks.

## Interface
- `WORD_SIZE`, 6: bits per word. Bits [WORD_SIZE-1:WORD_SIZE-2] select the destination FIFO; must be >= 3.
- `clk` input, 1 bit: single clock, all state on rising edge.
- `reset_L` input, 1 bit: asynchronous, active-low reset.
- `data_in0..data_in3` input, WORD_SIZE each: read data of input FIFO i. Valid the cycle after `pop_i` is high (synchronous read).
- `fifo_empty0..fifo_empty3` input, 1 each: registered empty flag of input FIFO i.
- `almost_full0..almost_full3` input, 1 each: almost_full of output FIFO i.
- `pop0..pop3` output, 1 each: `fifo_rd` to input FIFO i. Registered, one-hot or zero.
- `push0..push3` output, 1 each: `fifo_wr` to output FIFO i. Registered, one-hot or zero.
- `data_out` output, WORD_SIZE: write data shared by all output FIFOs. Meaningful only while a push is high.
- `idle` output, 1 bit: registered. High when no pop, no word in flight, and all input FIFOs are empty.

## Operation
- **Stall**
  - `stall = almost_full0 | almost_full1 | almost_full2 | almost_full3`.
  - While `stall` is high, no new pop is issued.
  - Words already popped still complete; in-flight depth is at most 2.
  - Output FIFO thresholds must leave at least 2 free entries.
- **Eligibility:** input i is eligible when `fifo_empty_i == 0` and i was not popped in the previous cycle.
  - The mask exists because `fifo_empty` updates one cycle after the read. Without it, a FIFO holding one word would be popped twice (underflow error).
- **Grant**
  - Round-robin pointer `last` (2 bits) holds the most recently granted index.
  - Search order is last+1, last+2, last+3, last, all mod 4. The first eligible index wins.
  - On a grant, `last` takes the winner. With no grant, `last` holds.
- **Pipeline**
  - S0, cycle t: grant computed and `pop_w` registered high for cycle t.
  - S1, cycle t+1: `data_in_w` is valid. Select it, decode `dst = data_in_w[WORD_SIZE-1:WORD_SIZE-2]`, and register.
  - S2, cycle t+2: `data_out` holds the word and `push_dst` is high for exactly one cycle.
- Pops may issue every cycle, to different FIFOs in successive cycles. One FIFO can be popped at most every other cycle.
- Word order from any single input FIFO is preserved. There is no ordering guarantee across inputs.
- **Reset mid-operation:** in-flight words are discarded. No push is issued for them after reset release.

## Timing
- **Reset values:**
  - `pop0..3 = 0`, `push0..3 = 0`, `data_out = 0`, `idle = 1`.
  - `last = 3`, so input 0 has first priority. Previous-pop mask cleared, pipeline valids cleared.
- **Latency:** `pop_i` at edge t leads to `push_dst` and `data_out` at edge t+2. Fixed 2 cycles, no bubbles added.
- **Throughput:** 1 word/cycle when at least 2 inputs are non-empty. 1 word per 2 cycles when a single input is non-empty.
- **Stall response:**
  - `almost_full` high in the cycle before edge t means no pop at edge t.
  - Its deassertion allows a pop at the next edge.
- **Simultaneous events:**
  - Stall and eligible inputs together: stall wins and the pointer holds.
  - Two pushes never coincide.
- `idle` is registered. It rises one cycle after the last push and drops in the cycle of a new pop.

## Test plan
- **Reset and basic routing:** reset, then input 0 holds one word 6'b10_0101, other inputs empty. Expect `pop0` for 1 cycle, then two cycles later `push2 = 1`, `data_out = 6'b100101`. `idle` returns to 1. No FIFO error flags.
- **Round-robin fairness:** all 4 inputs hold 3 words. Expect pop order 0,1,2,3,0,1,2,3,0,1,2,3 on consecutive cycles, then 12 pushes in the same order with no gaps.
- **Single-source throttling:** only input 1 holds 4 words. Expect `pop1` high on alternate cycles (4 pops over 7 cycles) and `fifo_empty1` never underflowing (`error` stays 0).
- **Backpressure:**
  - While streaming, raise `almost_full3` for 5 cycles.
  - No pops may start during those cycles.
  - At most 2 in-flight pushes complete.
  - Pops resume the cycle after deassertion, continuing from `last + 1`.
- **Reset mid-flight:** assert `reset_L = 0` asynchronously one cycle after a pop. Expect all pops and pushes to go 0 immediately, no push after release, and `last = 3`.
- **Destination sweep:** words with MSBs 00, 01, 10, 11 from inputs 3, 2, 1, 0. Each lands on `push0..push3` respectively with matching `data_out`.
